// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the 32-bit RISC datapath: fetch, then per-opcode
// T-states decoded from IR[31:27], one control word per clock.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RESET | held in reset, all outputs low
// S_PAUSE | stopped at an instruction boundary, waiting for stop to drop
// S_HALT  | halt executed; absorbing until reset
// S_T0    | fetch: PC -> MAR, PC+1 -> Z
// S_T1    | fetch: Z -> PC, memory read into MDR
// S_T2    | fetch: MDR -> IR
// S_T3-T7 | execute, per-opcode sequence
module control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        CONin,
  output logic        InPortout,
  output logic        OutPortin,
  output logic [4:0]  alu_op,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RESET, S_PAUSE, S_HALT,
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;

  state_t     state;
  state_t     last_t;
  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_mem, is_alu, is_imm, is_muldiv, is_unary, is_br;

  assign opcode    = IR[31:27];
  assign is_ld     = (opcode == OP_LD);
  assign is_ldi    = (opcode == OP_LDI);
  assign is_st     = (opcode == OP_ST);
  assign is_mem    = is_ld | is_ldi | is_st;
  assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_OR);
  assign is_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_br     = (opcode == OP_BR);

  // Final execute state per opcode; anything not recognised runs as a one-cycle nop.
  always_comb begin
    last_t = S_T3;
    if (is_ld || is_st)               last_t = S_T7;
    else if (is_muldiv || is_br)      last_t = S_T6;
    else if (is_ldi || is_alu || is_imm) last_t = S_T5;
    else if (is_unary)                last_t = S_T4;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET, S_PAUSE: state <= stop ? S_PAUSE : S_T0;
        S_HALT:           state <= S_HALT;
        default: begin
          if (state == last_t) begin
            if (opcode == OP_HALT) state <= S_HALT;
            else                   state <= stop ? S_PAUSE : S_T0;
          end else begin
            state <= state_t'(state + 4'd1);
          end
        end
      endcase
    end
  end

  // Control word decode. IR is loaded at the end of T2, so the opcode must be
  // decoded from the live IR rather than captured a cycle early.
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin} = '0;
    {Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout} = '0;
    {Cout, CONin, InPortout, OutPortin} = '0;
    alu_op = 5'b00000;
    Run    = (state != S_RESET) && (state != S_PAUSE) && (state != S_HALT);
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_unary) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else begin
          case (opcode)
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_mem) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        end else if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (is_ldi || is_alu || is_imm) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (is_br && CON) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected control words are queued per
// instruction from a table of the instruction set and compared every cycle.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic reset, stop, CON;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
  logic Read, Write, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
  logic Cout, CONin, InPortout, OutPortin, Run;
  logic [4:0] alu_op;
  logic [32:0] obs;
  logic [32:0] sb[$];
  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clock(clock), .reset(reset), .stop(stop), .IR(IR), .CON(CON),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .CONin(CONin), .InPortout(InPortout),
    .OutPortin(OutPortin), .alu_op(alu_op), .Run(Run)
  );

  always #5 clock = ~clock;

  assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin,
                MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                HIout, LOout, Cout, CONin, InPortout, OutPortin, alu_op, Run};

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int instr_len(input logic [4:0] op);
    case (op)
      5'd0, 5'd2:                return 8;
      5'd14, 5'd15, 5'd18:       return 7;
      5'd16, 5'd17:              return 5;
      default:                   return (op >= 5'd1 && op <= 5'd13) ? 6 : 4;
    endcase
  endfunction

  // Expected control word for cycle t (0 = T0) of an instruction with opcode op.
  function automatic logic [32:0] exp_word(input logic [4:0] op, input int t, input logic con);
    logic gra, grb, grc, rin, rout, baout, pcout, pcin, incpc, marin, mdrin, mdrout;
    logic rd, wr, irin, yin, zin, zlo, zhi, hiin, loin, hiout, loout, cout, conin, inp, outp;
    logic [4:0] alu;
    {gra, grb, grc, rin, rout, baout, pcout, pcin, incpc, marin, mdrin, mdrout} = '0;
    {rd, wr, irin, yin, zin, zlo, zhi, hiin, loin, hiout, loout, cout, conin, inp, outp} = '0;
    alu = 5'd0;
    if (t == 0) begin pcout = 1; marin = 1; incpc = 1; zin = 1; end
    else if (t == 1) begin zlo = 1; pcin = 1; rd = 1; mdrin = 1; end
    else if (t == 2) begin mdrout = 1; irin = 1; end
    else if (op <= 5'd2) begin
      case (t)
        3: begin grb = 1; baout = 1; yin = 1; end
        4: begin cout = 1; zin = 1; alu = 5'b00011; end
        5: if (op == 5'd1) begin zlo = 1; gra = 1; rin = 1; end
           else begin zlo = 1; marin = 1; end
        6: if (op == 5'd0) begin rd = 1; mdrin = 1; end
           else begin gra = 1; rout = 1; mdrin = 1; end
        7: if (op == 5'd0) begin mdrout = 1; gra = 1; rin = 1; end
           else wr = 1;
        default: ;
      endcase
    end else if (op <= 5'd13) begin
      case (t)
        3: begin grb = 1; rout = 1; yin = 1; end
        4: if (op <= 5'd10) begin grc = 1; rout = 1; zin = 1; alu = op; end
           else begin cout = 1; zin = 1; alu = op; end
        5: begin zlo = 1; gra = 1; rin = 1; end
        default: ;
      endcase
    end else if (op == 5'd14 || op == 5'd15) begin
      case (t)
        3: begin gra = 1; rout = 1; yin = 1; end
        4: begin grb = 1; rout = 1; zin = 1; alu = op; end
        5: begin zlo = 1; loin = 1; end
        6: begin zhi = 1; hiin = 1; end
        default: ;
      endcase
    end else if (op == 5'd16 || op == 5'd17) begin
      if (t == 3) begin grb = 1; rout = 1; zin = 1; alu = op; end
      else begin zlo = 1; gra = 1; rin = 1; end
    end else if (op == 5'd18) begin
      case (t)
        3: begin gra = 1; rout = 1; conin = 1; end
        4: begin pcout = 1; yin = 1; end
        5: begin cout = 1; zin = 1; alu = 5'b00011; end
        6: if (con) begin zlo = 1; pcin = 1; end
        default: ;
      endcase
    end else begin
      case (op)
        5'd19: begin gra = 1; rout = 1; pcin = 1; end
        5'd21: begin inp = 1; gra = 1; rin = 1; end
        5'd22: begin gra = 1; rout = 1; outp = 1; end
        5'd23: begin hiout = 1; gra = 1; rin = 1; end
        5'd24: begin loout = 1; gra = 1; rin = 1; end
        default: ;
      endcase
    end
    return {gra, grb, grc, rin, rout, baout, pcout, pcin, incpc, marin, mdrin, mdrout,
            rd, wr, irin, yin, zin, zlo, zhi, hiin, loin, hiout, loout, cout, conin,
            inp, outp, alu, 1'b1};
  endfunction

  // Entered at a negedge in RESET/PAUSE or a previous instruction's last state.
  // IR is updated only after the T0 comparison, as the real IR register would be.
  // stop_at raises stop after that cycle; ncyc > 0 truncates the run.
  task automatic run_instr(input logic [31:0] ir, input logic con,
                           input int stop_at, input int ncyc);
    int n;
    logic [32:0] e;
    n = (ncyc > 0) ? ncyc : instr_len(ir[31:27]);
    for (int t = 0; t < n; t++) sb.push_back(exp_word(ir[31:27], t, con));
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      e = sb.pop_front();
      chk($sformatf("op%0d_T%0d", ir[31:27], t), obs, e);
      if (t == 0) begin IR = ir; CON = con; end
      if (t == stop_at) stop = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    logic [32:0] e;
    for (int i = 0; i < n; i++) sb.push_back(33'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      e = sb.pop_front();
      chk($sformatf("%s_%0d", tag, i), obs, e);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  initial begin
    reset = 1'b1; stop = 1'b0; CON = 1'b0; IR = 32'd0;
    @(posedge clock);
    idle_cycles(1, "reset");
    reset = 1'b0;

    run_instr(mk(5'b00011, 4'd2, 4'd3, 4'd4), 1'b0, -1, 0);   // add
    run_instr(32'h0080_0005, 1'b0, -1, 0);                     // ld
    run_instr(mk(5'b00010, 4'd1, 4'd5, 4'd0), 1'b0, -1, 0);   // st
    run_instr(mk(5'b00001, 4'd6, 4'd0, 4'd0), 1'b0, -1, 0);   // ldi
    run_instr(mk(5'b01011, 4'd7, 4'd2, 4'd0), 1'b0, -1, 0);   // addi
    run_instr(mk(5'b01010, 4'd1, 4'd2, 4'd3), 1'b0, -1, 0);   // or
    run_instr(mk(5'b01110, 4'd3, 4'd4, 4'd0), 1'b0, -1, 0);   // mul
    run_instr(mk(5'b10000, 4'd5, 4'd6, 4'd0), 1'b0, -1, 0);   // neg
    run_instr(mk(5'b10010, 4'd2, 4'd0, 4'd0), 1'b0, -1, 0);   // br, not taken
    run_instr(mk(5'b10010, 4'd2, 4'd0, 4'd0), 1'b1, -1, 0);   // br, taken
    run_instr(mk(5'b10011, 4'd8, 4'd0, 4'd0), 1'b0, -1, 0);   // jr
    run_instr(mk(5'b10101, 4'd9, 4'd0, 4'd0), 1'b0, -1, 0);   // in
    run_instr(mk(5'b10110, 4'd9, 4'd0, 4'd0), 1'b0, -1, 0);   // out
    run_instr(mk(5'b10111, 4'd4, 4'd0, 4'd0), 1'b0, -1, 0);   // mfhi
    run_instr(mk(5'b11000, 4'd4, 4'd0, 4'd0), 1'b0, -1, 0);   // mflo
    run_instr(mk(5'b11001, 4'd0, 4'd0, 4'd0), 1'b0, -1, 0);   // nop

    run_instr(mk(5'b00011, 4'd2, 4'd3, 4'd4), 1'b0, 4, 0);    // stop raised in T4
    idle_cycles(3, "pause");
    stop = 1'b0;
    run_instr(mk(5'b01111, 4'd1, 4'd2, 4'd0), 1'b0, -1, 0);   // div resumes from PAUSE

    run_instr(mk(5'b11010, 4'd0, 4'd0, 4'd0), 1'b0, -1, 0);   // halt
    idle_cycles(20, "halt");
    reset = 1'b1;
    idle_cycles(1, "halt_reset");
    reset = 1'b0;

    run_instr(32'h0080_0005, 1'b0, -1, 6);                     // ld cut off in T5
    reset = 1'b1;
    idle_cycles(1, "mid_reset");
    reset = 1'b0;
    run_instr(mk(5'b10100, 4'd3, 4'd3, 4'd3), 1'b0, -1, 0);   // undefined -> nop
    run_instr(mk(5'b10001, 4'd1, 4'd2, 4'd0), 1'b0, -1, 0);   // not

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired Moore control unit for the 32-bit RISC datapath. It steps through fetch and per-opcode T-states, decoding IR[31:27]. Each cycle it drives one control word: the register-file group selects and strobes (Gra/Grb/Grc/Rin/Rout/BAout) consumed by SelectEncodeLogic, plus the PC, MAR, MDR, Y, Z, HI/LO, CON and port strobes.

## Interface
- No parameters.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; forces state RESET.
- stop  in  1  pause request, honoured only at instruction boundaries.
- IR  in  32  instruction register contents; opcode is IR[31:27].
- CON  in  1  branch-condition flip-flop output.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register group selects and strobes.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin  out  1 each.
- Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout, Cout, CONin, InPortout, OutPortin  out  1 each.
- alu_op  out  5  ALU function; equals the opcode while Zin is asserted, 5'b00011 (ADD) for address/PC arithmetic, else 0.
- Run  out  1  high while executing; low in RESET, PAUSE, HALT.

## Operation
- Opcodes: ld 00000, ldi 00001, st 00010, R-type ALU 00011–01010 (add, sub, shr, shl, ror, rol, and, or), addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010. Unlisted opcodes (incl. 10100) execute as nop.
- States: RESET, PAUSE, HALT, T0–T7. Outputs depend on the state register and, in T3+, on IR[31:27]; CON is used only in br T6. All signals not listed for a state are 0.
- Fetch: T0 PCout MARin IncPC Zin; T1 Zlowout PCin Read MDRin; T2 MDRout IRin.
- R-type: T3 Grb Rout Yin; T4 Grc Rout Zin; T5 Zlowout Gra Rin.
- neg/not: T3 Grb Rout Zin; T4 Zlowout Gra Rin.
- Immediate ALU (addi/andi/ori): T3 Grb Rout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
- ldi: T3 Grb BAout Yin; T4 Cout Zin (ADD); T5 Zlowout Gra Rin.
- ld: T3–T4 as ldi; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDRin; T7 Write.
- mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin; T5 Zlowout LOin; T6 Zhighout HIin.
- br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin (ADD); T6 Zlowout PCin if CON=1, otherwise an empty cycle.
- jr: T3 Gra Rout PCin. in: T3 InPortout Gra Rin. out: T3 Gra Rout OutPortin. mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin.
- nop: T3 empty cycle. halt: T3 empty cycle, then HALT.
- Exactly one of Gra/Grb/Grc is high whenever Rin, Rout or BAout is high. At most one bus driver (any *out signal) is high per cycle.

## Timing
- One state per clock. Reset: state RESET and all outputs 0 the cycle after reset is sampled high; this also applies mid-instruction, with no pending strobe completed.
- RESET → T0 (or PAUSE if stop=1) on the first clock with reset=0.
- Last T-state of each instruction → T0 if stop=0, PAUSE if stop=1. halt goes to HALT regardless of stop.
- PAUSE: all strobes 0, Run=0; moves to T0 on the first clock with stop=0.
- HALT: absorbing until reset; all outputs 0.
- stop raised mid-instruction has no effect until the instruction boundary.
- Instruction lengths in cycles including fetch: R-type 6, neg/not 5, imm 6, ldi 6, ld 8, st 8, mul/div 7, br 7, jr/in/out/mfhi/mflo/nop 4, halt 4 then HALT.
- Run=1 exactly in T0–T7.

## Test plan
- Reset then IR=add (opcode 00011, ra=2, rb=3, rc=4) → six cycles T0–T5 with the listed strobes; alu_op=00011 in T4 only; Gra+Rin in T5; back to T0.
- ld (IR=0x00800005) → eight cycles; MARin in T0 and T5; Read in T1 and T6; Gra+Rin in T7; Write never asserted.
- br with CON=0, then the same br with CON=1 → T6 has PCin=0 in the first case and Zlowout+PCin=1 in the second; 7 cycles both times.
- stop asserted during T4 of an add → add completes T5, enters PAUSE with Run=0; stop dropped → T0 on the next clock.
- halt opcode 11010 → T0–T3 then HALT, Run=0 held for 20 cycles; reset pulse → RESET then T0.
- reset asserted during ld T5 → all outputs 0 next cycle; undefined opcode 10100 → 4-cycle nop with no register strobes.
